i2c_wr_master: RTL and testbench

- Byte-level I2C write engine for the audio codec control path. It sits directly downstream of the codec register-config sequencer.
- Accepts one 24-bit write request {dev_addr, reg_addr, reg_data} over a level start/tr_end handshake. Serialises it as START + 3 bytes + STOP on the open-drain bus and reports the acknowledge result.
- Runs from the 12 MHz system clock and generates SCL internally, so the requester needs no divided clock.

---
 rtl/i2c_pkg.sv | 36 +++
 rtl/i2c_wr_master_if.sv | 35 +++
 rtl/i2c_qtick_gen.sv | 46 ++++
 rtl/i2c_wr_master.sv | 235 +++++++++++++++++++++++
 tb/tb_i2c_wr_master.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared types and constants for the I2C write engine and its quarter-tick
// generator (also intended for the future read engine).
//   state_t        : engine FSM encoding
//   qtr_t          : quarter index inside one SCL bit slot
//   BYTES_PER_XFER : bytes per write (device address, register, data)
//   DEF_*          : default timing constants
// -----------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BITS  = 3'd2,
    ACKS  = 3'd3,
    STOP  = 3'd4,
    DONE  = 3'd5,
    FREE  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } qtr_t;

  localparam int BYTES_PER_XFER = 3;

  localparam int DEF_CLK_FREQ  = 12_000_000;
  localparam int DEF_I2C_FREQ  = 100_000;
  localparam int DEF_QTR_CNT   = DEF_CLK_FREQ / (4 * DEF_I2C_FREQ);
  localparam int DEF_RETRY_MAX = 3;

endpackage

// File: rtl/i2c_wr_master_if.sv
// -----------------------------------------------------------------------------
// i2c_wr_master_if
// Request handshake between the codec config sequencer and the write engine.
//   start    : level request from the sequencer
//   i2c_data : {dev_addr, reg_addr, reg_data}, stable while start is high
//   tr_end   : transfer complete, held until start is seen low
//   ack      : 1 = every byte acknowledged, valid while tr_end = 1
//   busy     : engine occupied from capture until back in IDLE
// Modports: master = requesting sequencer, slave = the write engine.
// -----------------------------------------------------------------------------
interface i2c_wr_master_if;

  logic        start;
  logic [23:0] i2c_data;
  logic        tr_end;
  logic        ack;
  logic        busy;

  modport master (
    output start,
    output i2c_data,
    input  tr_end,
    input  ack,
    input  busy
  );

  modport slave (
    input  start,
    input  i2c_data,
    output tr_end,
    output ack,
    output busy
  );

endinterface

// File: rtl/i2c_qtick_gen.sv
// -----------------------------------------------------------------------------
// i2c_qtick_gen
// Divides clk_12M into quarter-SCL ticks and tracks which quarter of the bit
// slot is current.
//   clk_12M : system clock
//   rstn    : asynchronous active-low reset
//   clr     : synchronous clear, realigns the slot to Q0 / count 0
//   qtick   : high on the last cycle of each quarter
//   qtr     : current quarter Q0..Q3, advances on qtick
// -----------------------------------------------------------------------------
module i2c_qtick_gen
  import i2c_pkg::*;
#(
  parameter int QTR_CNT = DEF_QTR_CNT
) (
  input  logic clk_12M,
  input  logic rstn,
  input  logic clr,
  output logic qtick,
  output qtr_t qtr
);

  localparam int CW = (QTR_CNT > 1) ? $clog2(QTR_CNT) : 1;

  logic [CW-1:0] cnt_reg;
  qtr_t          qtr_reg;

  assign qtick = (cnt_reg == CW'(QTR_CNT - 1));
  assign qtr   = qtr_reg;

  always_ff @(posedge clk_12M or negedge rstn) begin
    if (!rstn) begin
      cnt_reg <= '0;
      qtr_reg <= Q0;
    end else if (clr) begin
      cnt_reg <= '0;
      qtr_reg <= Q0;
    end else if (qtick) begin
      cnt_reg <= '0;
      qtr_reg <= qtr_t'(qtr_reg + 2'd1);
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_wr_master.sv
// -----------------------------------------------------------------------------
// i2c_wr_master
// Byte-level I2C write engine for the audio codec control path. Captures one
// 24-bit word on a start/tr_end level handshake and sends START, three bytes
// and STOP, reporting whether every byte was acknowledged.
//   clk_12M  : system clock
//   rstn     : asynchronous active-low reset (aborts at once, no STOP)
//   req      : request handshake (i2c_wr_master_if.slave)
//   i2c_sclk : SCL, push-pull
//   i2c_sdat : SDA, open drain (0 or Z only)
// Build option: define I2C_NACK_RETRY_EN to re-send the latched word after a
// NACK (STOP, bus free, new START) up to RETRY_MAX extra attempts.
// -----------------------------------------------------------------------------
module i2c_wr_master
  import i2c_pkg::*;
#(
  parameter int CLK_FREQ  = DEF_CLK_FREQ,
  parameter int I2C_FREQ  = DEF_I2C_FREQ,
  parameter int QTR_CNT   = CLK_FREQ / (4 * I2C_FREQ)
`ifdef I2C_NACK_RETRY_EN
  ,
  parameter int RETRY_MAX = DEF_RETRY_MAX
`endif
) (
  input  logic             clk_12M,
  input  logic             rstn,
  i2c_wr_master_if.slave   req,
  output logic             i2c_sclk,
  inout  wire              i2c_sdat
);

  localparam int SDA_SYNC = 2;

  state_t      state_reg;
  logic [23:0] shift_reg;
  logic [2:0]  bit_cnt_reg;
  logic [1:0]  byte_idx_reg;
  logic        ack_acc_reg;
  logic        ack_bit_reg;
  logic        scl_reg;
  logic        sda_low_reg;
  logic        busy_reg;
  logic        tr_end_reg;
  logic        ack_reg;
`ifdef I2C_NACK_RETRY_EN
  logic [23:0] word_reg;
  logic [2:0]  retry_cnt_reg;
  logic        retry_pend_reg;
`endif

  logic qtick;
  qtr_t qtr;
  logic cap_go;
  logic done_go;
  logic slot_end;
  logic sda_in;
  logic sda_sync_reg [SDA_SYNC];

  // Both conditions restart the slot timing so the next slot begins at Q0.
  assign cap_go   = (state_reg == IDLE) && req.start && !tr_end_reg;
  assign done_go  = (state_reg == DONE) && tr_end_reg && !req.start;
  assign slot_end = qtick && (qtr == Q3);

  i2c_qtick_gen #(
    .QTR_CNT (QTR_CNT)
  ) u_qtick (
    .clk_12M (clk_12M),
    .rstn    (rstn),
    .clr     (cap_go || done_go),
    .qtick   (qtick),
    .qtr     (qtr)
  );

  // SDA comes from the pad; resynchronise before the ACK sample.
  generate
    for (genvar gi = 0; gi < SDA_SYNC; gi++) begin : g_sda_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk_12M or negedge rstn) begin
          if (!rstn) sda_sync_reg[gi] <= 1'b1;
          else       sda_sync_reg[gi] <= i2c_sdat;
        end
      end else begin : g_next
        always_ff @(posedge clk_12M or negedge rstn) begin
          if (!rstn) sda_sync_reg[gi] <= 1'b1;
          else       sda_sync_reg[gi] <= sda_sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign sda_in = sda_sync_reg[SDA_SYNC-1];

  assign i2c_sclk   = scl_reg;
  assign i2c_sdat   = sda_low_reg ? 1'b0 : 1'bz;
  assign req.busy   = busy_reg;
  assign req.tr_end = tr_end_reg;
  assign req.ack    = ack_reg;

  // Bus outputs are registered from the current state/quarter, so every
  // edge lands one clock after the quarter boundary, uniformly for all slots.
  always_ff @(posedge clk_12M or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      byte_idx_reg   <= '0;
      ack_acc_reg    <= 1'b0;
      ack_bit_reg    <= 1'b0;
      scl_reg        <= 1'b1;
      sda_low_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      tr_end_reg     <= 1'b0;
      ack_reg        <= 1'b0;
`ifdef I2C_NACK_RETRY_EN
      word_reg       <= '0;
      retry_cnt_reg  <= '0;
      retry_pend_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          scl_reg     <= 1'b1;
          sda_low_reg <= 1'b0;
          if (cap_go) begin
            shift_reg    <= req.i2c_data;
            busy_reg     <= 1'b1;
            ack_acc_reg  <= 1'b1;
            ack_reg      <= 1'b0;
            bit_cnt_reg  <= '0;
            byte_idx_reg <= '0;
            state_reg    <= START;
`ifdef I2C_NACK_RETRY_EN
            word_reg       <= req.i2c_data;
            retry_cnt_reg  <= '0;
            retry_pend_reg <= 1'b0;
`endif
          end
        end

        START: begin
          scl_reg     <= (qtr != Q3);
          sda_low_reg <= (qtr == Q2) || (qtr == Q3);
          if (slot_end) state_reg <= BITS;
        end

        BITS: begin
          scl_reg <= (qtr == Q2) || (qtr == Q3);
          // Q0 keeps the previous level; data changes only while SCL is low.
          if (qtr != Q0) sda_low_reg <= ~shift_reg[23];
          if (slot_end) begin
            shift_reg   <= {shift_reg[22:0], 1'b0};
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) state_reg <= ACKS;
          end
        end

        ACKS: begin
          scl_reg <= (qtr == Q2) || (qtr == Q3);
          if (qtr != Q0) sda_low_reg <= 1'b0;
          if (qtick && (qtr == Q2)) ack_bit_reg <= ~sda_in;
          if (slot_end) begin
            if (ack_bit_reg) begin
              if (byte_idx_reg == 2'(BYTES_PER_XFER - 1)) begin
                state_reg <= STOP;
              end else begin
                byte_idx_reg <= byte_idx_reg + 2'd1;
                state_reg    <= BITS;
              end
            end else begin
              ack_acc_reg <= 1'b0;
              state_reg   <= STOP;
`ifdef I2C_NACK_RETRY_EN
              if (retry_cnt_reg < 3'(RETRY_MAX)) begin
                retry_pend_reg <= 1'b1;
                retry_cnt_reg  <= retry_cnt_reg + 3'd1;
              end
`endif
            end
          end
        end

        STOP: begin
          scl_reg     <= (qtr != Q0);
          sda_low_reg <= (qtr != Q3);
          if (slot_end) begin
`ifdef I2C_NACK_RETRY_EN
            state_reg <= retry_pend_reg ? FREE : DONE;
`else
            state_reg <= DONE;
`endif
          end
        end

        DONE: begin
          scl_reg     <= 1'b1;
          sda_low_reg <= 1'b0;
          if (!tr_end_reg) begin
            tr_end_reg <= 1'b1;
            ack_reg    <= ack_acc_reg;
          end else if (done_go) begin
            tr_end_reg <= 1'b0;
            state_reg  <= FREE;
          end
        end

        FREE: begin
          scl_reg     <= 1'b1;
          sda_low_reg <= 1'b0;
          if (slot_end) begin
`ifdef I2C_NACK_RETRY_EN
            if (retry_pend_reg) begin
              // Re-send the word captured at request time.
              shift_reg      <= word_reg;
              ack_acc_reg    <= 1'b1;
              bit_cnt_reg    <= '0;
              byte_idx_reg   <= '0;
              retry_pend_reg <= 1'b0;
              state_reg      <= START;
            end else begin
              busy_reg  <= 1'b0;
              state_reg <= IDLE;
            end
`else
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
`endif
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_wr_master.sv
// -----------------------------------------------------------------------------
// tb_i2c_wr_master
// Directed bench for i2c_wr_master with a bus monitor / ACK-NACK slave model.
// Stimulus pushes the expected outcome of each request into a queue; the
// monitor decodes SCL/SDA, and on each tr_end rise pops and compares.
// -----------------------------------------------------------------------------
module tb_i2c_wr_master;

  logic clk_12M = 1'b0;
  logic rstn    = 1'b0;
  logic i2c_sclk;
  wire  i2c_sdat;
  logic slave_low = 1'b0;

  assign i2c_sdat = slave_low ? 1'b0 : 1'bz;
  pullup (i2c_sdat);

  i2c_wr_master_if req_if ();

  i2c_wr_master dut (
    .clk_12M  (clk_12M),
    .rstn     (rstn),
    .req      (req_if),
    .i2c_sclk (i2c_sclk),
    .i2c_sdat (i2c_sdat)
  );

  always #5 clk_12M = ~clk_12M;

`ifdef I2C_NACK_RETRY_EN
  localparam int NACK_LAT = 9961;  // 4 attempts x 20 slots + 3 free slots
  localparam int NACK_ATT = 4;
`else
  localparam int NACK_LAT = 2401;  // START + 18 slots + STOP, then +1
  localparam int NACK_ATT = 1;
`endif

  typedef struct {
    logic [23:0] word;
    logic        ack;
    int          pulses;
    int          nbits;
    int          lat;
    int          att;
  } exp_t;

  exp_t sb_q[$];

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- bus monitor + slave model ----------------
  int          cyc = 0;
  int          nack_byte = 0;
  int          npulses = 0;
  int          nbits = 0;
  logic [23:0] bus_word = '0;
  logic        hi_seen = 1'b0;
  logic        bit_val = 1'b0;
  int          rise_cyc = 0;
  int          last_rise = 0;
  int          per_err = 0;
  int          gap_err = 0;
  int          last_stop = 0;
  bit          have_stop = 1'b0;
  bit          stop_flag = 1'b0;
  int          attempts = 0;
  int          total_starts = 0;
  int          cap_cyc = 0;
  logic        prev_scl = 1'b1, prev_sda = 1'b1, prev_tr = 1'b0, prev_busy = 1'b0;

  initial begin
    logic cur_scl, cur_sda;
    exp_t e;
    forever begin
      @(posedge clk_12M);
      #1;
      cyc++;
      cur_scl = i2c_sclk;
      cur_sda = i2c_sdat;
      if (!rstn) begin
        slave_low = 1'b0;
        attempts  = 0;
        hi_seen   = 1'b0;
      end else begin
        if (prev_scl && cur_scl && prev_sda && !cur_sda) begin
          if (have_stop && (cyc - last_stop) < 120) gap_err++;
          npulses   = 0;
          nbits     = 0;
          bus_word  = '0;
          hi_seen   = 1'b0;
          per_err   = 0;
          stop_flag = 1'b0;
          slave_low = 1'b0;
          attempts++;
          total_starts++;
        end else if (prev_scl && cur_scl && !prev_sda && cur_sda) begin
          stop_flag = 1'b1;
          have_stop = 1'b1;
          last_stop = cyc;
          hi_seen   = 1'b0;
        end
        if (!prev_scl && cur_scl) begin
          hi_seen  = 1'b1;
          bit_val  = cur_sda;
          rise_cyc = cyc;
        end
        if (prev_scl && !cur_scl && hi_seen) begin
          hi_seen = 1'b0;
          npulses++;
          if (npulses > 1 && (rise_cyc - last_rise) != 120) per_err++;
          last_rise = rise_cyc;
          if (npulses % 9 != 0) begin
            bus_word = {bus_word[22:0], bit_val};
            nbits++;
          end
          if (npulses % 9 == 8) begin
            if (npulses / 9 + 1 != nack_byte) slave_low = 1'b1;
          end else if (npulses % 9 == 0) begin
            slave_low = 1'b0;
          end
        end
        if (!prev_busy && req_if.busy) cap_cyc = cyc;
        if (!prev_tr && req_if.tr_end) begin
          if (sb_q.size() == 0) begin
            chk("sb_unexpected_tr_end", 1, 0);
          end else begin
            e = sb_q.pop_front();
            chk("ack", int'(req_if.ack), int'(e.ack));
            chk("scl_pulses", npulses, e.pulses);
            chk("data_bits", nbits, e.nbits);
            chk("bus_word", int'(bus_word), int'(e.word) >> (24 - e.nbits));
            chk("latency", cyc - cap_cyc, e.lat);
            chk("stop_before_tr_end", int'(stop_flag), 1);
            chk("attempts", attempts, e.att);
            chk("scl_period_errs", per_err, 0);
            chk("bus_free_errs", gap_err, 0);
            $display("xfer word=%06h bus=%06h ack=%0d pulses=%0d lat=%0d att=%0d",
                     e.word, bus_word, req_if.ack, npulses, cyc - cap_cyc, attempts);
          end
          attempts = 0;
          gap_err  = 0;
        end
      end
      prev_scl  = cur_scl;
      prev_sda  = cur_sda;
      prev_tr   = req_if.tr_end;
      prev_busy = req_if.busy;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_xfer(input logic [23:0] w, input int nb, input logic e_ack,
                         input int e_pulses, input int e_bits, input int e_lat,
                         input int e_att, input int hold, input bit chg,
                         input logic [23:0] alt);
    exp_t e;
    int n;
    int starts0;
    e.word = w; e.ack = e_ack; e.pulses = e_pulses; e.nbits = e_bits;
    e.lat = e_lat; e.att = e_att;
    sb_q.push_back(e);
    nack_byte          = nb;
    req_if.i2c_data    = w;
    req_if.start       = 1'b1;
    n = 0;
    while (!req_if.tr_end && n < 20000) begin
      @(posedge clk_12M);
      #1;
      n++;
      if (chg && n == 1500) req_if.i2c_data = alt;
    end
    if (!req_if.tr_end) chk("tr_end_timeout", 0, 1);
    starts0 = total_starts;
    repeat (hold) begin
      @(posedge clk_12M);
      #1;
    end
    if (hold > 0) begin
      chk("hold_tr_end", int'(req_if.tr_end), 1);
      chk("hold_busy", int'(req_if.busy), 1);
      chk("hold_no_restart", total_starts - starts0, 0);
    end
    req_if.start = 1'b0;
    @(posedge clk_12M);
    #1;
    chk("tr_end_fall", int'(req_if.tr_end), 0);
    n = 0;
    while (req_if.busy && n < 1000) begin
      @(posedge clk_12M);
      #1;
      n++;
    end
    chk("busy_fall_delay", n, 120);
  endtask

  logic [23:0] seq_words [6] = '{24'h340017, 24'h340217, 24'h340479,
                                 24'h340679, 24'h340812, 24'h340A00};

  initial begin
    int n;
    req_if.start    = 1'b0;
    req_if.i2c_data = '0;
    repeat (4) @(posedge clk_12M);
    #1;
    chk("rst_busy", int'(req_if.busy), 0);
    chk("rst_tr_end", int'(req_if.tr_end), 0);
    chk("rst_ack", int'(req_if.ack), 0);
    chk("rst_scl", int'(i2c_sclk), 1);
    chk("rst_sda", int'(i2c_sdat), 1);
    rstn = 1'b1;
    repeat (3) @(posedge clk_12M);
    #1;

    // Full ACKed write
    do_xfer(24'h121000, 0, 1'b1, 27, 24, 3481, 1, 0, 1'b0, '0);
    // NACK on the second byte
    do_xfer(24'h34AB55, 2, 1'b0, 18, 16, NACK_LAT, NACK_ATT, 0, 1'b0, '0);
    // start held high long after tr_end
    do_xfer(24'h1A2B3C, 0, 1'b1, 27, 24, 3481, 1, 10000, 1'b0, '0);

    // Reset during bit 5 of the first byte
    nack_byte       = 0;
    req_if.i2c_data = 24'h5A5A5A;
    req_if.start    = 1'b1;
    n = 0;
    while (npulses != 5 && n < 5000) begin
      @(posedge clk_12M);
      #1;
      n++;
    end
    chk("reset_reach_bit5", npulses, 5);
    rstn = 1'b0;
    #1;
    chk("abort_sda", int'(i2c_sdat), 1);
    chk("abort_scl", int'(i2c_sclk), 1);
    chk("abort_busy", int'(req_if.busy), 0);
    chk("abort_tr_end", int'(req_if.tr_end), 0);
    req_if.start = 1'b0;
    repeat (3) @(posedge clk_12M);
    #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk_12M);
    #1;
    do_xfer(24'hA4C3F0, 0, 1'b1, 27, 24, 3481, 1, 0, 1'b0, '0);

    // Config sequencer burst
    for (int i = 0; i < 6; i++)
      do_xfer(seq_words[i], 0, 1'b1, 27, 24, 3481, 1, 0, 1'b0, '0);

    // i2c_data changes mid-transfer; the captured word must go out
    do_xfer(24'h3C5AF0, 0, 1'b1, 27, 24, 3481, 1, 0, 1'b1, 24'hFFFFFF);

    repeat (10) @(posedge clk_12M);
    #1;
    chk("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
